// File: rtl/x_mem_seq.sv
// x_mem_seq: loads a byte stream into x_mem, then plays the stored samples
// back at one sample per DIV clocks with a one-cycle valid strobe.
// Optional feature macro: X_MEM_SEQ_LOOP_EN (defined = endless looped playback,
// undefined = one-shot playback ending with o_done).
module x_mem_seq #(
   parameter int unsigned DIV    = 16,
   parameter int unsigned RD_LAT = 3
) (
   input  logic        i_clk,
   input  logic        i_nrst,
   input  logic        i_load,
   input  logic        i_wr_valid,
   input  logic [7:0]  i_wr_data,
   output logic        o_wr_ready,
   input  logic        i_play,
   input  logic        i_stop,
   output logic [11:0] o_len,
   output logic        o_busy,
   output logic        o_done,
   output logic [10:0] o_mem_addr,
   output logic        o_mem_we,
   output logic [7:0]  o_mem_wdata,
   input  logic [7:0]  i_mem_rdata,
   output logic [7:0]  o_sample,
   output logic        o_sample_valid
);

   localparam int unsigned AW    = 11;
   localparam int unsigned LW    = 12;
   localparam int unsigned DEPTH = 2048;
   localparam int unsigned CW    = (DIV > 1) ? $clog2(DIV) : 1;
   // One stage for the registered address plus RD_LAT stages inside x_mem.
   localparam int unsigned PW    = RD_LAT + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_PLAY = 2'd2
   } state_e;

   state_e        state_q;
   logic          busy_q;
   logic [LW-1:0] wptr_q;
   logic [LW-1:0] len_q;
   logic [AW-1:0] rptr_q;
   logic [CW-1:0] cnt_q;
   logic [PW-1:0] pipe_q;
   logic          last_q;
   logic          wr_ready_q;
   logic          done_q;
   logic [AW-1:0] mem_addr_q;
   logic          mem_we_q;
   logic [7:0]    mem_wdata_q;
   logic [7:0]    sample_q;
   logic          sample_valid_q;

   logic          accept;
   logic          issue;
   logic          last_rd;
   logic          emerge;
   logic          unused_rdata;

   // Handshake, read-issue and pipeline-exit decodes.
   assign accept  = (state_q == S_LOAD) && i_wr_valid && wr_ready_q;
   assign issue   = (state_q == S_PLAY) && (cnt_q == '0) && !last_q;
   assign last_rd = ({1'b0, rptr_q} == (len_q - LW'(1)));
   assign emerge  = pipe_q[PW-1];

   // Upper read-data bits carry nothing for the 6-bit DAC path.
   assign unused_rdata = ^i_mem_rdata[7:6];

   // Sequencer state machine with registered memory and sample outputs.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q        <= S_IDLE;
         busy_q         <= 1'b0;
         wptr_q         <= '0;
         len_q          <= '0;
         rptr_q         <= '0;
         cnt_q          <= '0;
         pipe_q         <= '0;
         last_q         <= 1'b0;
         wr_ready_q     <= 1'b0;
         done_q         <= 1'b0;
         mem_addr_q     <= '0;
         mem_we_q       <= 1'b0;
         mem_wdata_q    <= '0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
      end else begin
         mem_we_q       <= 1'b0;
         sample_valid_q <= 1'b0;
         done_q         <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               wr_ready_q <= 1'b0;
               if (i_load) begin
                  state_q    <= S_LOAD;
                  busy_q     <= 1'b1;
                  wptr_q     <= '0;
                  len_q      <= '0;
                  wr_ready_q <= 1'b1;
               end else if (i_play && (len_q != '0)) begin
                  state_q <= S_PLAY;
                  busy_q  <= 1'b1;
                  rptr_q  <= '0;
                  cnt_q   <= '0;
                  pipe_q  <= '0;
                  last_q  <= 1'b0;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  mem_addr_q  <= wptr_q[AW-1:0];
                  mem_we_q    <= 1'b1;
                  mem_wdata_q <= i_wr_data;
                  wptr_q      <= wptr_q + LW'(1);
                  len_q       <= len_q + LW'(1);
               end
               if ((accept && (wptr_q == LW'(DEPTH - 1))) || i_stop) begin
                  state_q    <= S_IDLE;
                  busy_q     <= 1'b0;
                  wr_ready_q <= 1'b0;
               end
            end
            S_PLAY: begin
               if (i_stop) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  pipe_q  <= '0;
               end else begin
                  cnt_q  <= (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
                  pipe_q <= {pipe_q[PW-2:0], issue};
                  if (issue) begin
                     mem_addr_q <= rptr_q;
                     if (last_rd) begin
`ifdef X_MEM_SEQ_LOOP_EN
                        rptr_q <= '0;
`else
                        last_q <= 1'b1;
`endif
                     end else begin
                        rptr_q <= rptr_q + AW'(1);
                     end
                  end
                  if (emerge) begin
                     sample_q       <= {2'b00, i_mem_rdata[5:0]};
                     sample_valid_q <= 1'b1;
                     if (last_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        pipe_q  <= '0;
                        last_q  <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_wr_ready     = wr_ready_q;
   assign o_len          = len_q;
   assign o_busy         = busy_q;
   assign o_done         = done_q;
   assign o_mem_addr     = mem_addr_q;
   assign o_mem_we       = mem_we_q;
   assign o_mem_wdata    = mem_wdata_q;
   assign o_sample       = sample_q;
   assign o_sample_valid = sample_valid_q;

endmodule

// File: tb/tb_x_mem_seq.sv
// Bench for x_mem_seq: table-driven load/play, hand-written stop and reset
// sequences, and randomized load/play against a sample-stream reference model.
module tb_x_mem_seq;

   localparam int DIV    = 16;
   localparam int RD_LAT = 3;
   localparam int LAT    = 2 + RD_LAT;

   logic        clk = 1'b0;
   logic        i_nrst = 1'b0;
   logic        i_load = 1'b0;
   logic        i_wr_valid = 1'b0;
   logic [7:0]  i_wr_data = 8'h00;
   logic        o_wr_ready;
   logic        i_play = 1'b0;
   logic        i_stop = 1'b0;
   logic [11:0] o_len;
   logic        o_busy;
   logic        o_done;
   logic [10:0] o_mem_addr;
   logic        o_mem_we;
   logic [7:0]  o_mem_wdata;
   logic [7:0]  i_mem_rdata;
   logic [7:0]  o_sample;
   logic        o_sample_valid;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the byte stream as sent, and its length.
   logic [7:0] ref_mem [0:2047];
   int         ref_len = 0;
   logic [7:0] obs_q [$];

   // x_mem model: write port plus 3-register read path.
   logic [7:0] xmem [0:2047];
   logic [7:0] rd1, rd2, rd3;
   int         wr_cnt = 0;

   typedef struct {
      logic [7:0]  wr_data;
      logic [10:0] exp_addr;
      logic [7:0]  exp_sample;
   } vec_t;
   vec_t tbl [4];

   x_mem_seq #(.DIV(DIV), .RD_LAT(RD_LAT)) dut (
      .i_clk(clk), .i_nrst(i_nrst), .i_load(i_load), .i_wr_valid(i_wr_valid),
      .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready), .i_play(i_play),
      .i_stop(i_stop), .o_len(o_len), .o_busy(o_busy), .o_done(o_done),
      .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
      .i_mem_rdata(i_mem_rdata), .o_sample(o_sample), .o_sample_valid(o_sample_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (o_mem_we) begin
         xmem[o_mem_addr] <= o_mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      rd1 <= xmem[o_mem_addr];
      rd2 <= rd1;
      rd3 <= rd2;
   end
   assign i_mem_rdata = rd3;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_mem(input string name, input int n);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) if (xmem[i] !== ref_mem[i]) bad++;
      check(name, 32'(bad), 32'd0);
   endtask

   // Load ref_mem[0..n-1] with optional valid bubbles, then stop.
   task automatic load_seq(input int n, input bit gaps, input string tag);
      int k;
      int guard;
      int w0;
      logic acc;
      w0 = wr_cnt;
      i_load = 1'b1; tick(); i_load = 1'b0;
      k = 0;
      guard = 0;
      while (k < n && guard < 20 * n + 50) begin
         i_wr_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         i_wr_data  = ref_mem[k];
         acc = i_wr_valid && o_wr_ready;
         tick();
         if (acc) k++;
         guard++;
      end
      i_wr_valid = 1'b0;
      check({tag, "_beats"}, 32'(k), 32'(n));
      i_stop = 1'b1; tick(); i_stop = 1'b0;
      check({tag, "_len"}, 32'(o_len), 32'(n));
      check({tag, "_busy"}, 32'(o_busy), 32'd0);
      check({tag, "_wrcnt"}, 32'(wr_cnt - w0), 32'(n));
      check_mem({tag, "_mem"}, n);
      ref_len = n;
   endtask

   // Play the stored stream; every cycle compared to the arithmetic schedule.
   task automatic play_check(input string tag);
      int  len;
      int  n_obs;
      int  last;
      int  k;
      logic ev;
      logic ed;
      logic [7:0] es;
      len = ref_len;
`ifdef X_MEM_SEQ_LOOP_EN
      n_obs = len + 1;
`else
      n_obs = len;
`endif
      last = LAT + (n_obs - 1) * DIV;
      obs_q.delete();
      i_play = 1'b1; tick(); i_play = 1'b0;
      check({tag, "_busy_start"}, 32'(o_busy), 32'd1);
      k = 0;
      for (int c = 1; c <= last + 2; c++) begin
         tick();
         ev = (c >= LAT) && (((c - LAT) % DIV) == 0) && (c <= last);
         ed = 1'b0;
`ifndef X_MEM_SEQ_LOOP_EN
         ed = (c == last);
`endif
         check({tag, "_valid"}, 32'(o_sample_valid), 32'(ev));
         check({tag, "_done"}, 32'(o_done), 32'(ed));
         if (ev) begin
            es = {2'b00, ref_mem[k % len][5:0]};
            check({tag, "_sample"}, 32'(o_sample), 32'(es));
            obs_q.push_back(o_sample);
            k++;
         end
      end
`ifdef X_MEM_SEQ_LOOP_EN
      check({tag, "_busy_loop"}, 32'(o_busy), 32'd1);
      i_stop = 1'b1; tick(); i_stop = 1'b0;
`endif
      check({tag, "_busy_end"}, 32'(o_busy), 32'd0);
   endtask

   initial begin
      int k;
      int guard;
      int w0;
      logic acc;

      tbl[0] = '{8'h11, 11'd0, 8'h11};
      tbl[1] = '{8'h22, 11'd1, 8'h22};
      tbl[2] = '{8'h33, 11'd2, 8'h33};
      tbl[3] = '{8'hFF, 11'd3, 8'h3F};

      // Reset state
      #12;
      check("rst_len", 32'(o_len), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_ready", 32'(o_wr_ready), 32'd0);
      check("rst_we", 32'(o_mem_we), 32'd0);
      check("rst_addr", 32'(o_mem_addr), 32'd0);
      check("rst_valid", 32'(o_sample_valid), 32'd0);
      check("rst_sample", 32'(o_sample), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      #1 i_nrst = 1'b1;
      tick();

      // Table-driven four-beat load
      i_load = 1'b1; tick(); i_load = 1'b0;
      check("tbl_ready", 32'(o_wr_ready), 32'd1);
      check("tbl_busy", 32'(o_busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         i_wr_valid = 1'b1;
         i_wr_data  = tbl[i].wr_data;
         ref_mem[i] = tbl[i].wr_data;
         tick();
         check("tbl_we", 32'(o_mem_we), 32'd1);
         check("tbl_addr", 32'(o_mem_addr), 32'(tbl[i].exp_addr));
         check("tbl_wdata", 32'(o_mem_wdata), 32'(tbl[i].wr_data));
      end
      i_wr_valid = 1'b0;
      tick();
      check("tbl_we_off", 32'(o_mem_we), 32'd0);
      check("tbl_len", 32'(o_len), 32'd4);
      i_stop = 1'b1; tick(); i_stop = 1'b0;
      check("tbl_idle", 32'(o_busy), 32'd0);
      check("tbl_len_kept", 32'(o_len), 32'd4);
      check_mem("tbl_mem", 4);
      ref_len = 4;

      // Play the four samples and compare against the table
      play_check("tbl_play");
      for (int i = 0; i < 4; i++) begin
         if (i < obs_q.size()) check("tbl_obs", 32'(obs_q[i]), 32'(tbl[i].exp_sample));
         else check("tbl_obs_missing", 32'(obs_q.size()), 32'(i + 1));
      end
`ifdef X_MEM_SEQ_LOOP_EN
      if (obs_q.size() > 4) check("tbl_obs_wrap", 32'(obs_q[4]), 32'h11);
      else check("tbl_obs_wrap_missing", 32'(obs_q.size()), 32'd5);
`endif

      // Stop two cycles after the second read issue
      i_play = 1'b1; tick(); i_play = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 19) i_stop = 1'b1;
         tick();
         i_stop = 1'b0;
         check("stop_valid", 32'(o_sample_valid), 32'(c == LAT));
         check("stop_done", 32'(o_done), 32'd0);
         if (c == 19) check("stop_idle", 32'(o_busy), 32'd0);
      end
      check("stop_len_kept", 32'(o_len), 32'd4);

      // Load and play together: load wins; then play with empty store
      i_load = 1'b1; i_play = 1'b1; tick(); i_load = 1'b0; i_play = 1'b0;
      check("both_ready", 32'(o_wr_ready), 32'd1);
      check("both_len", 32'(o_len), 32'd0);
      i_stop = 1'b1; tick(); i_stop = 1'b0;
      check("both_idle", 32'(o_busy), 32'd0);
      i_play = 1'b1; tick(); i_play = 1'b0;
      check("empty_play_busy", 32'(o_busy), 32'd0);
      tick();
      check("empty_play_busy2", 32'(o_busy), 32'd0);
      ref_len = 0;

      // Randomized load (with bubbles) and playback
      for (int it = 0; it < 5; it++) begin
         int n;
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) ref_mem[i] = 8'($urandom);
         load_seq(n, 1'b1, "rnd_load");
         play_check("rnd_play");
      end

      // Full memory with valid held high past the last beat
      for (int i = 0; i < 2048; i++) ref_mem[i] = 8'($urandom);
      w0 = wr_cnt;
      i_load = 1'b1; tick(); i_load = 1'b0;
      k = 0;
      guard = 0;
      i_wr_valid = 1'b1;
      while (k < 2048 && guard < 2100) begin
         i_wr_data = ref_mem[k];
         acc = o_wr_ready;
         tick();
         if (acc) k++;
         guard++;
      end
      check("full_beats", 32'(k), 32'd2048);
      check("full_ready", 32'(o_wr_ready), 32'd0);
      check("full_idle", 32'(o_busy), 32'd0);
      check("full_len", 32'(o_len), 32'd2048);
      check("full_last_addr", 32'(o_mem_addr), 32'd2047);
      i_wr_data = 8'hA5;
      tick();
      tick();
      i_wr_valid = 1'b0;
      check("full_wrcnt", 32'(wr_cnt - w0), 32'd2048);
      check("full_len_after", 32'(o_len), 32'd2048);
      check_mem("full_mem", 2048);
      ref_len = 2048;
      play_check("full_play");

      // Asynchronous reset in the middle of a load
      i_load = 1'b1; tick(); i_load = 1'b0;
      i_wr_valid = 1'b1; i_wr_data = 8'h5A; tick();
      i_wr_data = 8'h6B; tick();
      i_wr_valid = 1'b0;
      check("rml_len_pre", 32'(o_len), 32'd2);
      check("rml_we_pre", 32'(o_mem_we), 32'd1);
      #2 i_nrst = 1'b0;
      #1;
      check("rml_len", 32'(o_len), 32'd0);
      check("rml_busy", 32'(o_busy), 32'd0);
      check("rml_ready", 32'(o_wr_ready), 32'd0);
      check("rml_we", 32'(o_mem_we), 32'd0);
      check("rml_addr", 32'(o_mem_addr), 32'd0);
      check("rml_wdata", 32'(o_mem_wdata), 32'd0);
      #2 i_nrst = 1'b1;
      tick();
      ref_len = 0;
      i_play = 1'b1; tick(); i_play = 1'b0;
      check("rml_play_busy", 32'(o_busy), 32'd0);
      for (int c = 0; c < 8; c++) begin
         tick();
         check("rml_play_valid", 32'(o_sample_valid), 32'd0);
      end
      check("rml_play_busy_end", 32'(o_busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
